// File: rtl/avr_dmem_arbiter_pkg.sv
// Shared encodings for the avr_soc data-memory arbiter: arbiter state and
// the bus owner used both for the live grant and the pending read return.
package avr_dmem_arbiter_pkg;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_AUX  = 2'd2
   } owner_t;

endpackage

// File: rtl/avr_dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU has priority, aux master gets a forced
// grant after MAX_WAIT denied cycles and may lock the bus for short bursts.
module avr_dmem_arbiter
   import avr_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic              aux_lock,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int LOCK_W = $clog2(LOCK_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);
   localparam logic [LOCK_W-1:0] LOCK_TOP = LOCK_W'(LOCK_MAX);

   function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
      return (v == WAIT_TOP) ? v : v + WAIT_W'(1);
   endfunction

   function automatic logic [LOCK_W-1:0] lock_sat_inc(input logic [LOCK_W-1:0] v);
      return (v == LOCK_TOP) ? v : v + LOCK_W'(1);
   endfunction

   arb_state_t        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [LOCK_W-1:0] lock_nxt;
   owner_t            gnt_p0;
   owner_t            rd_owner_p0, rd_owner_p1;

   // Stage p0: combinational grant and next-state decision
   always_comb begin
      gnt_p0     = OWN_NONE;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      lock_cnt_d = lock_cnt_q;
      lock_nxt   = lock_sat_inc(lock_cnt_q);

      case (state_q)
         ST_ARB: begin
            if (aux_req && (wait_cnt_q == WAIT_TOP)) begin
               gnt_p0 = OWN_AUX;
            end else if (cpu_req) begin
               gnt_p0 = OWN_CPU;
            end else if (aux_req) begin
               gnt_p0 = OWN_AUX;
            end
            // A one-cycle burst limit leaves nothing to hold after the first grant.
            if ((gnt_p0 == OWN_AUX) && aux_lock && (LOCK_MAX > 1)) begin
               state_d    = ST_LOCK;
               lock_cnt_d = LOCK_W'(1);
            end
         end
         ST_LOCK: begin
            if (aux_req) begin
               gnt_p0 = OWN_AUX;
            end
            // The burst limit counts this cycle's grant, so LOCK_MAX grants in total.
            if (aux_req && aux_lock && (lock_nxt < LOCK_TOP)) begin
               lock_cnt_d = lock_nxt;
            end else begin
               state_d    = ST_ARB;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
         end
      endcase

      if (!aux_req || (gnt_p0 == OWN_AUX) || (state_q == ST_LOCK)) begin
         wait_cnt_d = '0;
      end else begin
         wait_cnt_d = wait_sat_inc(wait_cnt_q);
      end

      if (reset) begin
         gnt_p0 = OWN_NONE;
      end
   end

   always_comb begin
      rd_owner_p0 = OWN_NONE;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (gnt_p0)
         OWN_CPU: begin
            mem_we      = cpu_we;
            mem_addr    = cpu_addr;
            mem_wdata   = cpu_wdata;
            rd_owner_p0 = cpu_we ? OWN_NONE : OWN_CPU;
         end
         OWN_AUX: begin
            mem_we      = aux_we;
            mem_addr    = aux_addr;
            mem_wdata   = aux_wdata;
            rd_owner_p0 = aux_we ? OWN_NONE : OWN_AUX;
         end
         default: begin
            rd_owner_p0 = OWN_NONE;
         end
      endcase
   end

   assign mem_en    = (gnt_p0 != OWN_NONE);
   assign aux_gnt   = (gnt_p0 == OWN_AUX);
   assign cpu_stall = !reset && cpu_req && (gnt_p0 != OWN_CPU);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_ARB;
         wait_cnt_q  <= '0;
         lock_cnt_q  <= '0;
         rd_owner_p1 <= OWN_NONE;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         rd_owner_p1 <= rd_owner_p0;
      end
   end

   // Stage p1: SRAM read data returns; only the owner's valid qualifies it
   assign cpu_rvalid = (rd_owner_p1 == OWN_CPU);
   assign aux_rvalid = (rd_owner_p1 == OWN_AUX);
   assign cpu_rdata  = mem_rdata;
   assign aux_rdata  = mem_rdata;

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Scoreboard bench for avr_dmem_arbiter: directed cycles push expected bus
// behaviour and read returns; a negedge monitor pops and compares.
module tb_avr_dmem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
   logic [ADDR_W-1:0] aux_addr;
   logic [DATA_W-1:0] aux_wdata, aux_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   avr_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // SRAM model: synchronous write, read data one cycle after the enable
   logic [DATA_W-1:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
      if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic              en, we, stall, gnt;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      string             nm;
   } cyc_t;

   typedef struct {
      int                due;
      logic [DATA_W-1:0] data;
      string             nm;
   } rd_t;

   cyc_t cyc_q[$];
   rd_t  cpu_q[$];
   rd_t  aux_q[$];
   int   cyc_n = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc_n++;

   task automatic step(input logic rst_v,
                       input logic cr, input logic cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                       input logic ar, input logic aw, input logic al, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic e_en, input logic e_we, input logic e_stall, input logic e_gnt,
                       input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_wd,
                       input int rd_who, input logic [DATA_W-1:0] rd_data, input string nm);
      cyc_t c;
      rd_t  r;
      @(posedge clk);
      #1;
      reset = rst_v;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      aux_req = ar; aux_we = aw; aux_lock = al; aux_addr = aa; aux_wdata = ad;
      c = '{e_en, e_we, e_stall, e_gnt, e_addr, e_wd, nm};
      cyc_q.push_back(c);
      r = '{cyc_n + 1, rd_data, nm};
      if (rd_who == 1) cpu_q.push_back(r);
      else if (rd_who == 2) aux_q.push_back(r);
   endtask

   task automatic idle(input string nm);
      step(1'b0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 16'h0, 8'h0, 0, 0, 0, 0, 16'h0, 8'h0, 0, 8'h0, nm);
   endtask

   // Monitor: bus-side checks every cycle, read returns whenever a valid shows
   always @(negedge clk) begin : mon
      cyc_t c;
      rd_t  r;
      if (cyc_q.size() > 0) begin
         c = cyc_q.pop_front();
         checks++;
         if ({mem_en, mem_we, cpu_stall, aux_gnt, mem_addr, mem_wdata} !==
             {c.en, c.we, c.stall, c.gnt, c.addr, c.wd}) begin
            errors++;
            $display("FAIL %s cyc %0d: got en=%b we=%b stall=%b gnt=%b addr=%h wd=%h want en=%b we=%b stall=%b gnt=%b addr=%h wd=%h",
                     c.nm, cyc_n, mem_en, mem_we, cpu_stall, aux_gnt, mem_addr, mem_wdata,
                     c.en, c.we, c.stall, c.gnt, c.addr, c.wd);
         end
      end
      if (cpu_rvalid) begin
         checks++;
         if (cpu_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_rvalid cyc %0d: got unexpected rvalid data=%h want no rvalid", cyc_n, cpu_rdata);
         end else begin
            r = cpu_q.pop_front();
            if (r.due != cyc_n || cpu_rdata !== r.data) begin
               errors++;
               $display("FAIL %s cpu_rd: got cyc=%0d data=%h want cyc=%0d data=%h", r.nm, cyc_n, cpu_rdata, r.due, r.data);
            end
         end
      end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc_n) begin
         checks++;
         errors++;
         r = cpu_q.pop_front();
         $display("FAIL %s cpu_rd: got no rvalid at cyc %0d want data=%h", r.nm, cyc_n, r.data);
      end
      if (aux_rvalid) begin
         checks++;
         if (aux_q.size() == 0) begin
            errors++;
            $display("FAIL aux_rvalid cyc %0d: got unexpected rvalid data=%h want no rvalid", cyc_n, aux_rdata);
         end else begin
            r = aux_q.pop_front();
            if (r.due != cyc_n || aux_rdata !== r.data) begin
               errors++;
               $display("FAIL %s aux_rd: got cyc=%0d data=%h want cyc=%0d data=%h", r.nm, cyc_n, aux_rdata, r.due, r.data);
            end
         end
      end else if (aux_q.size() > 0 && aux_q[0].due <= cyc_n) begin
         checks++;
         errors++;
         r = aux_q.pop_front();
         $display("FAIL %s aux_rd: got no rvalid at cyc %0d want data=%h", r.nm, cyc_n, r.data);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 0; aux_we = 0; aux_lock = 0; aux_addr = '0; aux_wdata = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0100] = 8'h5A;
      mem[16'h0101] = 8'h11;
      mem[16'h0102] = 8'h22;
      mem[16'h0200] = 8'h33;
      mem[16'h0300] = 8'h44;

      // Reset: requests present but every bus output held at 0
      step(1, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 16'h0200, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, "rst_hold");
      step(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, "rst_idle");
      reset = 1'b0;

      // CPU-only read, write, read-back
      step(0, 1, 0, 16'h0100, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 16'h0100, 8'h00, 1, 8'h5A, "cpu_rd");
      idle("idle_a");
      step(0, 1, 1, 16'h0104, 8'h9C, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 16'h0104, 8'h9C, 0, 8'h00, "cpu_wr");
      step(0, 1, 0, 16'h0104, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 16'h0104, 8'h00, 1, 8'h9C, "cpu_rd_back");
      idle("idle_b");

      // Starvation: aux forced in every 5th cycle, first cycle is the simultaneous case
      for (int i = 0; i < 10; i++) begin
         if (i % 5 == 4)
            step(0, 1, 0, 16'h0100, 8'h00, 1, 0, 0, 16'h0200, 8'h00, 1, 0, 1, 1, 16'h0200, 8'h00, 2, 8'h33, "starve_aux");
         else
            step(0, 1, 0, 16'h0100, 8'h00, 1, 0, 0, 16'h0200, 8'h00, 1, 0, 0, 0, 16'h0100, 8'h00, 1, 8'h5A, "starve_cpu");
      end
      idle("idle_c");

      // Locked read-modify-write burst, CPU granted right after lock exit
      step(0, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0200, 8'h00, 1, 0, 0, 1, 16'h0200, 8'h00, 2, 8'h33, "lk_rd");
      step(0, 1, 0, 16'h0101, 8'h00, 1, 1, 1, 16'h0200, 8'h77, 1, 1, 1, 1, 16'h0200, 8'h77, 0, 8'h00, "lk_wr");
      step(0, 1, 0, 16'h0101, 8'h00, 1, 0, 0, 16'h0200, 8'h00, 1, 0, 1, 1, 16'h0200, 8'h00, 2, 8'h77, "lk_last");
      step(0, 1, 0, 16'h0101, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 16'h0101, 8'h00, 1, 8'h11, "lk_exit_cpu");
      idle("idle_d");

      // Lock limit: 8 aux grants, then CPU wins despite aux still locking
      step(0, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0300, 8'h00, 1, 0, 0, 1, 16'h0300, 8'h00, 2, 8'h44, "lim_first");
      for (int i = 1; i < 8; i++)
         step(0, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 16'h0300, 8'h00, 1, 0, 1, 1, 16'h0300, 8'h00, 2, 8'h44, "lim_burst");
      for (int i = 0; i < 2; i++)
         step(0, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 16'h0300, 8'h00, 1, 0, 0, 0, 16'h0100, 8'h00, 1, 8'h5A, "lim_cpu");
      idle("idle_e");

      // Reset mid-LOCK just after a read grant: the return must vanish at once
      step(0, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0200, 8'h00, 1, 0, 0, 1, 16'h0200, 8'h00, 0, 8'h00, "pre_rst");
      step(1, 1, 0, 16'h0100, 8'h00, 1, 0, 1, 16'h0200, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, "rst_async");
      step(1, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, "rst_idle2");
      reset = 1'b0;
      step(0, 1, 0, 16'h0100, 8'h00, 1, 0, 0, 16'h0200, 8'h00, 1, 0, 0, 0, 16'h0100, 8'h00, 1, 8'h5A, "post_rst_cpu");
      idle("idle_f");
      idle("idle_g");

      @(negedge clk);
      #1;
      checks++;
      if (cyc_q.size() != 0 || cpu_q.size() != 0 || aux_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got pending cyc=%0d cpu=%0d aux=%0d want 0 0 0",
                  cyc_q.size(), cpu_q.size(), aux_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avr_dmem_arbiter.md
Name: avr_dmem_arbiter

Overview:
Arbitrates the single-port data SRAM of avr_soc between the CPU data port and an auxiliary master (UART debug/loader bridge or DMA).
- CPU has priority by default; the aux master is guaranteed progress through a starvation counter.
- The aux master may lock the bus for short atomic read-modify-write bursts.
- Sits between the CPU core, the aux master and the data SRAM inside avr_soc.

Parameters:
ADDR_W, 16, data address width
DATA_W, 8, data width
MAX_WAIT, 4, consecutive aux-denied cycles before aux is forced a grant (must be >= 1)
LOCK_MAX, 8, maximum consecutive aux-granted cycles in a locked burst (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU requests an access this cycle
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  CPU request not serviced this cycle; CPU must hold its request
cpu_rdata  out  DATA_W  read data, qualified by cpu_rvalid
cpu_rvalid  out  1  CPU read data valid
aux_req  in  1  aux requests an access
aux_we  in  1  1=write
aux_lock  in  1  request to keep the bus after this access
aux_addr  in  ADDR_W  aux address
aux_wdata  in  DATA_W  aux write data
aux_gnt  out  1  aux access performed this cycle
aux_rdata  out  DATA_W  read data, qualified by aux_rvalid
aux_rvalid  out  1  aux read data valid
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- States: ARB (normal arbitration) and LOCK (aux owns the bus). Registered wait_cnt saturates at MAX_WAIT; lock_cnt counts granted cycles in LOCK.
- Grant decision is combinational from current state and requests. mem_* are combinationally muxed from the winner. No added latency on the request path.
- ARB:
  - aux_req && wait_cnt==MAX_WAIT -> grant aux.
  - Else cpu_req -> grant CPU.
  - Else aux_req -> grant aux.
  - Else idle: mem_en=0.
- LOCK: aux_req=1 -> grant aux; CPU is never granted in LOCK.
- cpu_stall = cpu_req && !cpu_granted. aux_gnt = aux granted.
- wait_cnt:
  - Increments when aux_req && !aux_gnt.
  - Clears when aux_gnt is asserted or aux_req=0.
- Transitions:
  - ARB -> LOCK when aux is granted with aux_lock=1; lock_cnt set to 1.
  - LOCK stays while aux_req && aux_lock && lock_cnt < LOCK_MAX. Each grant increments lock_cnt.
  - Any other case in LOCK -> ARB, with wait_cnt cleared. A CPU request in the first ARB cycle after exit therefore always wins.
- Read return:
  - Registered rd_owner (none/cpu/aux) captures the granted requester on a read grant.
  - The next cycle asserts the matching rvalid for exactly 1 cycle.
  - cpu_rdata and aux_rdata pass mem_rdata through unconditionally; only rvalid qualifies them.
- Writes produce no rvalid.
- Back-to-back reads may alternate owners: each rvalid follows its own grant by exactly 1 cycle.
- Reset (async, any state including mid-LOCK):
  - state=ARB, wait_cnt=0, lock_cnt=0, rd_owner=none.
  - cpu_rvalid=0, aux_rvalid=0. A pending read return is dropped.
  - While reset is high, mem_en, mem_we, aux_gnt and cpu_stall are forced 0. mem_addr and mem_wdata are 0.
- Counter widths: $clog2(MAX_WAIT+1) and $clog2(LOCK_MAX+1).
- No arithmetic overflow is possible: both counters saturate.

Decomposition:
- State encodings (ARB/LOCK) and rd_owner encodings go in the shared avr defines include.
- No sub-module required. The saturating counter stays inline.

Test Plan:
- CPU-only traffic: cpu_req=1 read at 0x0100, SRAM holds 0x5A -> mem_en=1 same cycle, cpu_stall=0, cpu_rvalid=1 next cycle with cpu_rdata=0x5A.
- Continuous CPU reads with aux_req=1 from cycle 0 (MAX_WAIT=4) -> aux denied cycles 0-3 with cpu_stall=0; cycle 4 aux_gnt=1 and cpu_stall=1; cycle 5 CPU regains the bus; pattern repeats every 5 cycles.
- Locked burst: aux read 0x0200 with aux_lock=1, then write 0x0200 with lock, then lock dropped -> CPU stalled throughout; aux_rvalid 1 cycle after the read; CPU granted in the cycle after lock exit.
- Lock limit: aux holds aux_lock=1 and aux_req=1 indefinitely (LOCK_MAX=8) -> exactly 8 aux grants, then the CPU is granted at least 1 cycle.
- Reset asserted mid-LOCK with a read in flight -> outputs are 0 immediately (async); no rvalid after reset release; first post-reset CPU request is granted.
- Simultaneous cpu_req and aux_req with wait_cnt=0, both reads -> CPU granted; aux_gnt=0; wait_cnt=1; no aux_rvalid.
